// File: rtl/cpu_mul_pkg.sv
// Shared widths and stage payload types for the 32x32 multiplier combine pipeline.
// CPU_MUL_HI_EN widens the payloads to carry the high partial product and high result word.
package cpu_mul_pkg;

  localparam int MUL_PP_W  = 32;
  localparam int MUL_MID_W = 33;
  localparam int MUL_TAG_W = 5;

  // Stage A: middle partial products already summed, low and high products carried raw.
  typedef struct packed {
    logic [MUL_MID_W-1:0] mid;
`ifdef CPU_MUL_HI_EN
    logic [MUL_PP_W-1:0]  p4;
`endif
    logic [MUL_PP_W-1:0]  p1;
  } stage_a_t;

  typedef struct packed {
`ifdef CPU_MUL_HI_EN
    logic [MUL_PP_W-1:0] hi;
`endif
    logic [MUL_PP_W-1:0] lo;
  } stage_b_t;

  // Final alignment of the middle term; carries past the result width are dropped.
  function automatic stage_b_t combine(input stage_a_t a);
    stage_b_t r;
`ifdef CPU_MUL_HI_EN
    r = stage_b_t'((2*MUL_PP_W)'({a.p4, a.p1}) + (2*MUL_PP_W)'({a.mid, 16'h0000}));
`else
    r.lo = MUL_PP_W'({a.mid, 16'h0000} + {17'h0_0000, a.p1});
`endif
    return r;
  endfunction

endpackage

// File: rtl/cpu_mul_pipe_reg.sv
// Generic valid/ready register slice with synchronous squash and active-low synchronous reset.
// Accepts new data whenever it is empty or its current contents leave on the same edge.
module cpu_mul_pipe_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  // Held low during reset and squash so an upstream producer never sees a false handshake.
  assign in_ready = reset_n && !flush && (!out_valid || out_ready);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) out_data <= in_data;
    end
  end

endmodule

// File: rtl/cpu_mul_combine.sv
// Two-stage combine of multiplier partial products into the unsigned product of src1*src2.
// Define CPU_MUL_HI_EN to add the p4 input and the out_result_hi output (full 64-bit product).
module cpu_mul_combine
  import cpu_mul_pkg::*;
#(
  parameter int TAG_W = MUL_TAG_W
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [MUL_PP_W-1:0] p1,
  input  logic [MUL_PP_W-1:0] p2,
  input  logic [MUL_PP_W-1:0] p3,
`ifdef CPU_MUL_HI_EN
  input  logic [MUL_PP_W-1:0] p4,
  output logic [MUL_PP_W-1:0] out_result_hi,
`endif
  input  logic [TAG_W-1:0]    in_tag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [MUL_PP_W-1:0] out_result,
  output logic [TAG_W-1:0]    out_tag
);

  localparam int A_W = $bits(stage_a_t) + TAG_W;
  localparam int B_W = $bits(stage_b_t) + TAG_W;

  stage_a_t         a_in;
  stage_a_t         a_out;
  stage_b_t         b_in;
  stage_b_t         b_out;
  logic [TAG_W-1:0] a_tag;
  logic [A_W-1:0]   a_q;
  logic [B_W-1:0]   b_q;
  logic             a_valid;
  logic             b_ready;

  always_comb begin
    a_in     = '0;
    a_in.mid = {1'b0, p2} + {1'b0, p3};
    a_in.p1  = p1;
`ifdef CPU_MUL_HI_EN
    a_in.p4  = p4;
`endif
  end

  cpu_mul_pipe_reg #(.W(A_W)) stage_a (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   ({a_in, in_tag}),
    .out_valid (a_valid),
    .out_ready (b_ready),
    .out_data  (a_q)
  );

  assign a_out = a_q[A_W-1:TAG_W];
  assign a_tag = a_q[TAG_W-1:0];
  assign b_in  = combine(a_out);

  cpu_mul_pipe_reg #(.W(B_W)) stage_b (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_valid  (a_valid),
    .in_ready  (b_ready),
    .in_data   ({b_in, a_tag}),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (b_q)
  );

  assign b_out      = b_q[B_W-1:TAG_W];
  assign out_tag    = b_q[TAG_W-1:0];
  assign out_result = b_out.lo;
`ifdef CPU_MUL_HI_EN
  assign out_result_hi = b_out.hi;
`endif

endmodule

// File: tb/tb_cpu_mul_combine.sv
// Scoreboard bench for cpu_mul_combine: directed corner cases plus randomized src1*src2 traffic.
// Expected products come from plain 64-bit multiplication of the random source operands.
module tb_cpu_mul_combine;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] p1, p2, p3;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_tag;
`ifdef CPU_MUL_HI_EN
  logic [31:0] p4;
  logic [31:0] out_result_hi;
`endif

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic [4:0]  tag;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic acc, rdy, ov;
  logic [31:0] q1, q2, q3, q4, elo, ehi;

  always #5 clk = ~clk;

  cpu_mul_combine #(.TAG_W(5)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .p1            (p1),
    .p2            (p2),
    .p3            (p3),
`ifdef CPU_MUL_HI_EN
    .p4            (p4),
    .out_result_hi (out_result_hi),
`endif
    .in_tag        (in_tag),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_result    (out_result),
    .out_tag       (out_tag)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: partial products and the product itself from the source operands.
  task automatic makeOp(input logic [31:0] s1, input logic [31:0] s2,
                        output logic [31:0] o1, output logic [31:0] o2,
                        output logic [31:0] o3, output logic [31:0] o4,
                        output logic [31:0] lo, output logic [31:0] hi);
    logic [63:0] full;
    full = {32'h0, s1} * {32'h0, s2};
    o1 = {16'h0, s1[15:0]}  * {16'h0, s2[15:0]};
    o2 = {16'h0, s1[15:0]}  * {16'h0, s2[31:16]};
    o3 = {16'h0, s1[31:16]} * {16'h0, s2[15:0]};
    o4 = {16'h0, s1[31:16]} * {16'h0, s2[31:16]};
    lo = full[31:0];
    hi = full[63:32];
  endtask

  // One cycle of stimulus: drive after the edge, sample handshake at negedge, log accepted ops.
  task automatic applyStimulus(input logic v, input logic [31:0] a1, input logic [31:0] a2,
                               input logic [31:0] a3, input logic [31:0] a4, input logic [4:0] t,
                               input logic ordy, input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                               output logic accepted, output logic ready_seen, output logic valid_seen);
    exp_t e;
    in_valid  = v;
    p1        = a1;
    p2        = a2;
    p3        = a3;
`ifdef CPU_MUL_HI_EN
    p4        = a4;
`endif
    in_tag    = t;
    out_ready = ordy;
    @(negedge clk);
    ready_seen = in_ready;
    valid_seen = out_valid;
    accepted   = v && in_ready;
    if (accepted) begin
      e.lo  = exp_lo;
      e.hi  = exp_hi;
      e.tag = t;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic ordy);
    logic a, r, o;
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'h0, ordy, 32'h0, 32'h0, a, r, o);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      idle(1'b1);
      n++;
    end
    checkOutput("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  // Monitor: every output handshake must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL unexpected_output: got tag %0d result 0x%0h, required no output", out_tag, out_result);
      end else begin
        mon_e = sb.pop_front();
        checkOutput("result_lo", 64'(out_result), 64'(mon_e.lo));
        checkOutput("result_tag", 64'(out_tag), 64'(mon_e.tag));
`ifdef CPU_MUL_HI_EN
        checkOutput("result_hi", 64'(out_result_hi), 64'(mon_e.hi));
`endif
      end
    end
  end

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int issued;
    int cycles;
    logic [31:0] s1, s2;
    logic v, r;

    reset_n = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    p1 = '0; p2 = '0; p3 = '0;
`ifdef CPU_MUL_HI_EN
    p4 = '0;
`endif
    in_tag = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_out_result", 64'(out_result), 64'd0);
    checkOutput("reset_out_tag", 64'(out_tag), 64'd0);
    checkOutput("reset_in_ready", 64'(in_ready), 64'd0);
    reset_n = 1'b1;
    applyStimulus(1'b1, 32'h8, 32'h6, 32'h4, 32'h3, 5'd7, 1'b1, 32'h000A_0008, 32'h0000_0003, acc, rdy, ov);
    checkOutput("first_ready_after_reset", 64'(rdy), 64'd1);
    checkOutput("directed_accept", 64'(acc), 64'd1);
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b1, 32'h0, 32'h0, acc, rdy, ov);
    checkOutput("latency_cycle1_valid", 64'(ov), 64'd0);
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b1, 32'h0, 32'h0, acc, rdy, ov);
    checkOutput("latency_cycle2_valid", 64'(ov), 64'd1);
    drain();

    applyStimulus(1'b1, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0, 5'd9, 1'b1, 32'h0000_FFFF, 32'h0000_0001, acc, rdy, ov);
    checkOutput("carry_accept", 64'(acc), 64'd1);
    drain();

    $display("[TB] back-to-back throughput");
    for (int i = 0; i < 4; i++) begin
      s1 = $urandom; s2 = $urandom;
      makeOp(s1, s2, q1, q2, q3, q4, elo, ehi);
      applyStimulus(1'b1, q1, q2, q3, q4, 5'(10 + i), 1'b1, elo, ehi, acc, rdy, ov);
      checkOutput("throughput_ready", 64'(rdy), 64'd1);
    end
    drain();

    $display("[TB] backpressure with full pipeline");
    for (int i = 1; i <= 3; i++) begin
      s1 = $urandom; s2 = $urandom;
      makeOp(s1, s2, q1, q2, q3, q4, elo, ehi);
      applyStimulus(1'b1, q1, q2, q3, q4, 5'(i), 1'b0, elo, ehi, acc, rdy, ov);
      checkOutput("stall_ready", 64'(rdy), (i == 3) ? 64'd0 : 64'd1);
    end
    applyStimulus(1'b1, q1, q2, q3, q4, 5'd3, 1'b1, elo, ehi, acc, rdy, ov);
    checkOutput("stall_release_accept", 64'(acc), 64'd1);
    drain();

    $display("[TB] flush with full pipeline");
    for (int i = 4; i <= 5; i++) begin
      s1 = $urandom; s2 = $urandom;
      makeOp(s1, s2, q1, q2, q3, q4, elo, ehi);
      applyStimulus(1'b1, q1, q2, q3, q4, 5'(i), 1'b0, elo, ehi, acc, rdy, ov);
    end
    flush = 1'b1;
    applyStimulus(1'b1, q1, q2, q3, q4, 5'd6, 1'b0, elo, ehi, acc, rdy, ov);
    checkOutput("flush_in_ready", 64'(rdy), 64'd0);
    flush = 1'b0;
    sb.delete();
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b1, 32'h0, 32'h0, acc, rdy, ov);
    checkOutput("flush_out_valid", 64'(ov), 64'd0);
    repeat (4) idle(1'b1);

    $display("[TB] reset mid-stream");
    for (int i = 0; i < 2; i++) begin
      s1 = $urandom; s2 = $urandom;
      makeOp(s1, s2, q1, q2, q3, q4, elo, ehi);
      applyStimulus(1'b1, q1, q2, q3, q4, 5'(20 + i), 1'b0, elo, ehi, acc, rdy, ov);
    end
    reset_n = 1'b0;
    idle(1'b0);
    sb.delete();
    checkOutput("midreset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("midreset_out_result", 64'(out_result), 64'd0);
    checkOutput("midreset_out_tag", 64'(out_tag), 64'd0);
    checkOutput("midreset_in_ready", 64'(in_ready), 64'd0);
`ifdef CPU_MUL_HI_EN
    checkOutput("midreset_out_hi", 64'(out_result_hi), 64'd0);
`endif
    reset_n = 1'b1;
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b1, 32'h0, 32'h0, acc, rdy, ov);
    checkOutput("release_in_ready", 64'(rdy), 64'd1);
    checkOutput("release_out_valid", 64'(ov), 64'd0);
    repeat (3) idle(1'b1);

    $display("[TB] random traffic");
    issued = 0;
    cycles = 0;
    while (issued < 10000 && cycles < 60000) begin
      s1 = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
      s2 = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
      makeOp(s1, s2, q1, q2, q3, q4, elo, ehi);
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 3) != 0);
      applyStimulus(v, q1, q2, q3, q4, 5'($urandom_range(0, 31)), r, elo, ehi, acc, rdy, ov);
      if (acc) issued++;
      cycles++;
    end
    checkOutput("random_issued", 64'(issued), 64'd10000);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_mul_combine.md
CPU_MUL_COMBINE -- requirements
Module: cpu_mul_combine

Interface
REQ-001 Parameter TAG_W, default 5: width of the destination-register tag carried alongside each product.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  reset is synchronous and active-low.
REQ-004 flush  input  1  synchronous squash of all in-flight operations.
REQ-005 in_valid  input  1  partial products and tag valid this cycle.
REQ-006 in_ready  output  1  block accepts the input this cycle.
REQ-007 p1  input  32  product src1[15:0]*src2[15:0], from the multiplier cell.
REQ-008 p2  input  32  product src1[15:0]*src2[31:16].
REQ-009 p3  input  32  product src1[31:16]*src2[15:0].
REQ-010 in_tag  input  TAG_W  destination tag.
REQ-011 out_valid  output  1  out_result and out_tag valid.
REQ-012 out_ready  input  1  consumer takes the output this cycle.
REQ-013 out_result  output  32  low 32 bits of src1*src2, unsigned.
REQ-014 out_tag  output  TAG_W  tag of the result.

Function
REQ-015 Transfer occurs when valid && ready on the same edge; a holder SHALL keep data stable while valid && !ready.
REQ-016 Stage A SHALL register mid = p2 + p3 (33 bits), p1 and in_tag.
REQ-017 Stage B SHALL register out_result = (p1 + (mid << 16)) mod 2^32.
REQ-018 Latency SHALL be exactly 2 cycles from input transfer to out_valid when out_ready is held high.
REQ-019 Throughput SHALL be one operation per cycle when out_ready is held high; there are no bubbles.
REQ-020 Each stage SHALL advance when it is empty or when its downstream accepts its data.
REQ-021 in_ready = !flush && (stage A empty || stage A advances); it SHALL be combinational from stage-B occupancy and out_ready.
REQ-022 When both stages are full and out_ready=0, in_ready SHALL be 0 and no data is lost or duplicated.
REQ-023 Arithmetic overflow above bit 31 SHALL be discarded silently; no status flag.
REQ-024 flush=1 SHALL clear both stage valid bits on the next edge.
REQ-025 flush=1 with in_valid=1 SHALL drop the input; flush wins over every other event.
REQ-026 Operations are tagged; ordering SHALL be strict FIFO.

Reset
REQ-027 On an edge with reset_n=0: out_valid=0, out_result=0, out_tag=0, and all stage valids and data are 0.
REQ-028 Reset asserted mid-operation SHALL discard all in-flight operations; in_ready SHALL be 0 while reset_n=0.
REQ-029 In the first cycle after reset release, in_ready SHALL be 1.

Configuration
REQ-030 Macro CPU_MUL_HI_EN SHALL control the high-word feature.
REQ-031 With CPU_MUL_HI_EN defined, the block SHALL add input p4[31:0] (src1[31:16]*src2[31:16]) and output out_result_hi[31:0].
REQ-032 With CPU_MUL_HI_EN defined, stage B SHALL compute {out_result_hi, out_result} = ({p4, p1} + (mid << 16)) mod 2^64, giving the full unsigned 64-bit product.
REQ-033 With CPU_MUL_HI_EN defined, out_result_hi SHALL reset to 0 and p4 SHALL be carried through stage A.
REQ-034 Without CPU_MUL_HI_EN, the p4 and out_result_hi ports and their logic SHALL be absent.
REQ-035 Without CPU_MUL_HI_EN, out_result SHALL be identical to REQ-017.

Structure
REQ-036 Package cpu_mul_pkg SHALL hold MUL_PP_W=32, MUL_MID_W=33, the default TAG_W and a stage payload struct typedef.
REQ-037 Sub-module cpu_mul_pipe_reg SHALL be a generic valid/ready register slice with flush, instantiated once per stage.

Verification
REQ-038 The bench SHALL cover: p1=0x8, p2=0x6, p3=0x4, p4=0x3, tag=7 -> after 2 cycles out_result=0x000A0008, out_tag=7, out_result_hi=0x00000003 (HI_EN).
REQ-039 The bench SHALL cover: p1=0xFFFFFFFF, p2=0x1, p3=0, p4=0 -> out_result=0x0000FFFF, out_result_hi=0x00000001 (carry into high word).
REQ-040 The bench SHALL cover: 3 back-to-back inputs with out_ready=0 -> in_ready drops after 2 are accepted; raising out_ready yields tags in order with no loss.
REQ-041 The bench SHALL cover: flush in the cycle both stages are full and in_valid=1 -> next cycle out_valid=0, and the dropped input never appears.
REQ-042 The bench SHALL cover: reset_n=0 for one cycle mid-stream -> all outputs 0 next cycle, in_ready=1 after release.
REQ-043 The bench SHALL cover: 10k random p1..p4 against a golden model derived from random src1/src2, with random out_ready -> every result equals src1*src2 (low, and high with HI_EN).
